score_event_queue: RTL

//  Upstream feeder for the HEX score counter. Collects alien-hit events from collision logic
//  (one bit per alien row type, several may fire in one cycle) and replays each as a
//  one-cycle, one-hot score1..score4 pulse, spaced so the counter's registered carry logic settles.

---
 rtl/score_event_queue_pkg.sv | 12 +
 rtl/score_event_queue_rr_arb4.sv | 26 ++
 rtl/score_event_queue.sv | 122 ++++++++++++
 3 files changed

// File: rtl/score_event_queue_pkg.sv
// Shared types for the score event queue: type count, FSM states, type index.
package score_pkg;
  localparam int NUM_TYPES = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_GAP} state_t;

  typedef logic [1:0] type_idx_t;

  function automatic type_idx_t next_idx(input type_idx_t i);
    return i + type_idx_t'(1);
  endfunction
endpackage

// File: rtl/score_event_queue_rr_arb4.sv
// Combinational 4-way round-robin arbiter; search begins at ptr and wraps.
module rr_arb4
  import score_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld
);
  type_idx_t idx;

  always_comb begin
    idx     = '0;
    gnt_idx = ptr;
    gnt_vld = 1'b0;
    for (int k = 0; k < NUM_TYPES; k++) begin
      idx = ptr + type_idx_t'(k);
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
    gnt = gnt_vld ? (4'b0001 << gnt_idx) : 4'b0000;
  end
endmodule

// File: rtl/score_event_queue.sv
// Buffers per-type hit events in saturating counters and replays them as spaced
// one-hot score pulses so the downstream counter's carries can settle.
module score_event_queue
  import score_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int GAP   = 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    hit,
  input  logic          clear,
  output logic          score1,
  output logic          score2,
  output logic          score3,
  output logic          score4,
  output logic          busy,
  output logic [CW+1:0] pending,
  output logic          dropped
);
  localparam int GW = $clog2(GAP + 1);

  logic [NUM_TYPES-1:0][CW-1:0] cnt_q, cnt_d;
  state_t                       state_q, state_d;
  logic [GW-1:0]                gap_q, gap_d;
  type_idx_t                    ptr_q, ptr_d;
  logic [3:0]                   score_q, score_d;
  logic                         dropped_q, dropped_d;

  logic [3:0] req, gnt, granted;
  type_idx_t  gnt_idx;
  logic       gnt_vld;
  logic       flush;

  assign flush = reset | clear;

  always_comb begin
    for (int i = 0; i < NUM_TYPES; i++) req[i] = (cnt_q[i] != '0);
  end

  rr_arb4 u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // A grant only happens from IDLE; it decrements the counter on the same edge.
  assign granted = (state_q == ST_IDLE) ? gnt : 4'b0000;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    ptr_d   = ptr_q;
    score_d = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          state_d = ST_PULSE;
          score_d = gnt;
          ptr_d   = next_idx(gnt_idx);
        end
      end
      ST_PULSE: begin
        state_d = ST_GAP;
        gap_d   = GW'(GAP - 1);
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      gap_d   = '0;
      ptr_d   = '0;
      score_d = 4'b0000;
    end
  end

  // Simultaneous hit and grant cancel out, so a full type never drops in that case.
  always_comb begin
    dropped_d = dropped_q;
    for (int i = 0; i < NUM_TYPES; i++) begin
      cnt_d[i] = cnt_q[i];
      if (hit[i] && !granted[i]) begin
        if (cnt_q[i] == CW'(DEPTH)) dropped_d = 1'b1;
        else                        cnt_d[i]  = cnt_q[i] + CW'(1);
      end else if (!hit[i] && granted[i]) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end
    if (flush) begin
      cnt_d     = '0;
      dropped_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    gap_q     <= gap_d;
    ptr_q     <= ptr_d;
    score_q   <= score_d;
    cnt_q     <= cnt_d;
    dropped_q <= dropped_d;
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < NUM_TYPES; i++) pending = pending + {2'b00, cnt_q[i]};
  end

  assign busy    = (pending != '0) | (state_q != ST_IDLE);
  assign dropped = dropped_q;
  assign score1  = score_q[0];
  assign score2  = score_q[1];
  assign score3  = score_q[2];
  assign score4  = score_q[3];
endmodule
